// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, add/sub FSM states and flag-vector layout.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_t;

  localparam int unsigned FLG_SIGN   = 0;
  localparam int unsigned FLG_ZERO   = 1;
  localparam int unsigned FLG_CARRY  = 2;
  localparam int unsigned FLG_PARITY = 3;
  localparam int unsigned FLG_OVF    = 4;
  localparam int unsigned NUM_FLAGS  = 5;

  typedef logic [NUM_FLAGS-1:0] flags_t;

  // SUB and SBB share op[0]; they add the complement of y.
  function automatic logic op_is_sub(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit combinational ripple adder built from full-adder cells.
module addsub_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract unit: one CHUNK slice per clock, LSB first, with
// persistent carry for ADC/SBB and valid/ready handshakes on both sides.
module chunked_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             zero,
  output logic             carry,
  output logic             parity,
  output logic             overflow
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             c_q, c_d;
  flags_t           flags_q, flags_d;

  logic [CHUNK-1:0] a_s, b_s, sum_s;
  logic             cout_s;
  int unsigned      base;

  always_comb begin
    base = 32'(idx_q) * CHUNK;
    a_s  = x_q[base +: CHUNK];
    b_s  = y_q[base +: CHUNK];
  end

  addsub_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a   (a_s),
    .b   (b_s),
    .cin (c_q),
    .sum (sum_s),
    .cout(cout_s)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    z_d     = z_q;
    c_d     = c_q;
    flags_d = flags_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d   = x;
          y_d   = op_is_sub(op) ? ~y : y;
          idx_d = '0;
          acc_d = '0;
          unique case (op)
            OP_ADD:  c_d = 1'b0;
            OP_SUB:  c_d = 1'b1;
            default: c_d = flags_q[FLG_CARRY];
          endcase
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d[base +: CHUNK] = sum_s;
        c_d   = cout_s;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          // Last slice: publish result and flags together; carry flag persists.
          idx_d               = '0;
          z_d                 = acc_d;
          flags_d[FLG_SIGN]   = acc_d[WIDTH-1];
          flags_d[FLG_ZERO]   = (acc_d == '0);
          flags_d[FLG_CARRY]  = cout_s;
          flags_d[FLG_PARITY] = ~^acc_d;
          flags_d[FLG_OVF]    = (x_q[WIDTH-1] == y_q[WIDTH-1]) &&
                                (acc_d[WIDTH-1] != x_q[WIDTH-1]);
          state_d             = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      c_q     <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign z         = z_q;
  assign sign      = flags_q[FLG_SIGN];
  assign zero      = flags_q[FLG_ZERO];
  assign carry     = flags_q[FLG_CARRY];
  assign parity    = flags_q[FLG_PARITY];
  assign overflow  = flags_q[FLG_OVF];

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub: 16/4 default instance plus an 8/1 instance.
module tb_chunked_addsub;

  typedef struct {
    logic [15:0] z;
    logic [4:0]  f;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-bit / 4-bit instance
  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b1;
  logic [15:0] x16 = '0, y16 = '0, z16;
  logic [1:0]  op16 = 2'b00;
  logic        s16, zr16, c16, p16, o16;

  // 8-bit / 1-bit instance
  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
  logic [7:0]  x8 = '0, y8 = '0, z8;
  logic [1:0]  op8 = 2'b00;
  logic        s8, zr8, c8, p8, o8;

  chunked_addsub dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .x(x16), .y(y16), .op(op16),
    .out_valid(ov16), .out_ready(or16), .z(z16), .sign(s16), .zero(zr16), .carry(c16),
    .parity(p16), .overflow(o16)
  );

  chunked_addsub #(.WIDTH(8), .CHUNK(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8), .op(op8),
    .out_valid(ov8), .out_ready(or8), .z(z8), .sign(s8), .zero(zr8), .carry(c8),
    .parity(p8), .overflow(o8)
  );

  int total = 0;
  int bad   = 0;
  exp_t q16[$];
  exp_t q8[$];
  int cyc = 0, acc16 = 0, acc8 = 0, lat16 = 0, lat8 = 0;
  logic pov16 = 1'b0, pov8 = 1'b0;
  exp_t e16, e8;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic logic [4:0] fl(input logic s, zr, c, p, o);
    return {o, p, c, zr, s};
  endfunction

  // Accept-edge bookkeeping for latency measurement.
  always @(posedge clk) begin
    if (iv16 && ir16) acc16 = cyc + 1;
    if (iv8 && ir8)   acc8  = cyc + 1;
    cyc = cyc + 1;
  end

  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (ov16 && !pov16) lat16 = cyc - acc16;
      if (ov16 && or16) begin
        if (q16.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected16: got z=%h want no output", z16);
        end else begin
          e16 = q16.pop_front();
          chk("z16", 32'(z16), 32'(e16.z));
          chk("flags16", 32'(fl(s16, zr16, c16, p16, o16)), 32'(e16.f));
          chk("lat16", lat16, e16.lat);
        end
      end
    end
    pov16 = ov16;
  end

  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (ov8 && !pov8) lat8 = cyc - acc8;
      if (ov8 && or8) begin
        if (q8.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected8: got z=%h want no output", z8);
        end else begin
          e8 = q8.pop_front();
          chk("z8", 32'(z8), 32'(e8.z));
          chk("flags8", 32'(fl(s8, zr8, c8, p8, o8)), 32'(e8.f));
          chk("lat8", lat8, e8.lat);
        end
      end
    end
    pov8 = ov8;
  end

  task automatic issue16(input logic [1:0] o, input logic [15:0] a, b, ez, input logic [4:0] ef);
    exp_t e;
    int n = 0;
    e.z = ez; e.f = ef; e.lat = 4;
    q16.push_back(e);
    @(negedge clk);
    while (!ir16 && n < 50) begin @(negedge clk); n++; end
    op16 = o; x16 = a; y16 = b; iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
  endtask

  task automatic issue8(input logic [1:0] o, input logic [7:0] a, b, ez, input logic [4:0] ef);
    exp_t e;
    int n = 0;
    e.z = {8'h00, ez}; e.f = ef; e.lat = 8;
    q8.push_back(e);
    @(negedge clk);
    while (!ir8 && n < 50) begin @(negedge clk); n++; end
    op8 = o; x8 = a; y8 = b; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  task automatic drain16();
    int n = 0;
    while (q16.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain16", q16.size(), 0);
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain8", q8.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_in_ready16", 32'(ir16), 1);
    chk("rst_out_valid16", 32'(ov16), 0);
    chk("rst_z16", 32'(z16), 0);
    chk("rst_flags16", 32'(fl(s16, zr16, c16, p16, o16)), 0);
    chk("rst_in_ready8", 32'(ir8), 1);
    chk("rst_out_valid8", 32'(ov8), 0);
    rst = 1'b0;

    // op: 0 ADD, 1 SUB, 2 ADC, 3 SBB; flags (s, zero, c, p, ovf)
    issue16(2'b00, 16'h7FFF, 16'h0001, 16'h8000, fl(1, 0, 0, 0, 1)); drain16();
    issue16(2'b01, 16'h0005, 16'h0005, 16'h0000, fl(0, 1, 1, 1, 0)); drain16();
    issue16(2'b01, 16'h0001, 16'h0002, 16'hFFFF, fl(1, 0, 0, 1, 0)); drain16();
    issue16(2'b00, 16'hFFFF, 16'h0001, 16'h0000, fl(0, 1, 1, 1, 0)); drain16();
    issue16(2'b10, 16'h0000, 16'h0000, 16'h0001, fl(0, 0, 0, 0, 0)); drain16();
    issue16(2'b11, 16'h0003, 16'h0001, 16'h0001, fl(0, 0, 1, 0, 0)); drain16();

    // Back-pressure: hold result in DONE while a new request is offered.
    or16 = 1'b0;
    issue16(2'b00, 16'h1234, 16'h1111, 16'h2345, fl(0, 0, 0, 1, 0));
    n = 0;
    while (!ov16 && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", 32'(ov16), 1);
      chk("bp_z", 32'(z16), 32'h2345);
      chk("bp_flags", 32'(fl(s16, zr16, c16, p16, o16)), 32'(fl(0, 0, 0, 1, 0)));
      chk("bp_in_ready", 32'(ir16), 0);
      op16 = 2'b00; x16 = 16'h0F0F; y16 = 16'h0101; iv16 = 1'b1;
      @(negedge clk);
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    n = 0;
    while (ov16 && n < 10) begin @(negedge clk); n++; end
    chk("bp_release_in_ready", 32'(ir16), 1);
    @(negedge clk);
    chk("bp_no_phantom", 32'(ir16), 1);
    drain16();

    // Reset mid-op: leave carry=1 and z nonzero first.
    issue16(2'b00, 16'hFFFF, 16'h0002, 16'h0001, fl(0, 0, 1, 0, 0)); drain16();
    @(negedge clk);
    op16 = 2'b00; x16 = 16'h0001; y16 = 16'h0001; iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(ov16), 0);
    chk("rst_mid_z", 32'(z16), 0);
    chk("rst_mid_carry", 32'(c16), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_in_ready", 32'(ir16), 1);
    issue16(2'b10, 16'h0000, 16'h0000, 16'h0000, fl(0, 1, 0, 1, 0)); drain16();

    // Bit-serial instance
    issue8(2'b01, 8'h80, 8'h01, 8'h7F, fl(0, 0, 1, 0, 1)); drain8();
    issue8(2'b00, 8'h7F, 8'h01, 8'h80, fl(1, 0, 0, 0, 1)); drain8();
    issue8(2'b10, 8'h10, 8'h01, 8'h11, fl(0, 0, 0, 1, 0)); drain8();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
